write_bpm_link: RTL

Aurora AXI-stream transmitter that serializes one BPM reading (112-bit header/X/Y/S record) into the four-word BPM link packet (header word carrying the 0xA5BE magic, X, Y, S), matching the existing BPM link receive path. It sits in the Aurora TX user-clock domain between the BPM reading source and the Aurora core's TX user interface; the Aurora core appends the CRC. A one-deep pending buffer absorbs a reading arriving mid-packet; further readings are dropped and counted.

---
 rtl/write_bpm_link.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/write_bpm_link.sv
// BPM link transmitter: turns one 112-bit BPM reading into a four-word
// AXI-stream packet (header, X, Y, S) for the Aurora TX user interface.
// A one-deep pending buffer holds a reading that arrives mid-packet;
// anything beyond that is dropped and counted.
//
// Handshake: a word is transferred on a cycle where TVALID && TREADY are
// both high at the rising edge; while TVALID is high and TREADY is low,
// TDATA/TLAST/TVALID hold their values. All outputs come from registers.
module write_bpm_link (
  input  logic         clk,
  input  logic         reset,
  input  logic         inputStrobe,
  input  logic [111:0] inputData,
  input  logic         inhibit,
  output logic [31:0]  TDATA,
  output logic         TVALID,
  output logic         TLAST,
  input  logic         TREADY,
  output logic         busy,
  output logic         sentStrobe,
  output logic [15:0]  sentCount,
  output logic         dropStrobe,
  output logic [15:0]  dropCount,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_X      = 3'd2,
    S_Y      = 3'd3,
    S_S      = 3'd4
  } state_t;

  state_t         state, state_d;
  logic [111:0]   act_q, act_d;
  logic [111:0]   pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic           hs, accept, end_pkt, drop;
  logic [31:0]    word_d;

  assign hs        = TVALID && TREADY;
  assign accept    = inputStrobe && !inhibit;
  assign end_pkt   = (state == S_S) && hs;
  assign dbg_state = state;

  // Next state, active/pending routing and drop decision.
  always_comb begin
    state_d      = state;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop         = 1'b0;

    if (hs) begin
      unique case (state)
        S_HEADER: state_d = S_X;
        S_X:      state_d = S_Y;
        S_Y:      state_d = S_S;
        S_S: begin
          if (pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
            state_d      = S_HEADER;
          end else begin
            state_d = S_IDLE;
          end
        end
        default:  state_d = state;
      endcase
    end

    if (accept) begin
      if ((state == S_IDLE) || (end_pkt && !pend_valid_q)) begin
        act_d   = inputData;
        state_d = S_HEADER;
      end else if (end_pkt && pend_valid_q) begin
        // Pending already promoted to active above; newcomer takes its slot.
        pend_d       = inputData;
        pend_valid_d = 1'b1;
      end else if (!pend_valid_q) begin
        pend_d       = inputData;
        pend_valid_d = 1'b1;
      end else begin
        // Oldest reading wins; the pending slot is left as is.
        drop = 1'b1;
      end
    end
  end

  // Word selection for the upcoming cycle; S bit 30 is always sent as 0.
  always_comb begin
    word_d = 32'h0;
    unique case (state_d)
      S_HEADER: word_d = {16'hA5BE, act_d[111:96]};
      S_X:      word_d = act_d[95:64];
      S_Y:      word_d = act_d[63:32];
      S_S:      word_d = act_d[31:0] & 32'hBFFF_FFFF;
      default:  word_d = 32'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Active and pending reading storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Registered AXI-stream outputs and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      TDATA  <= 32'h0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      TDATA  <= word_d;
      TVALID <= (state_d != S_IDLE);
      TLAST  <= (state_d == S_S);
      busy   <= (state_d != S_IDLE) || pend_valid_d;
    end
  end

  // Sent (wrapping) and drop (saturating) counters with their pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sentStrobe <= 1'b0;
      sentCount  <= 16'h0;
      dropStrobe <= 1'b0;
      dropCount  <= 16'h0;
    end else begin
      sentStrobe <= end_pkt;
      dropStrobe <= drop;
      if (end_pkt) sentCount <= sentCount + 16'd1;
      if (drop && (dropCount != 16'hFFFF)) dropCount <= dropCount + 16'd1;
    end
  end

endmodule
